// File: rtl/fft_agu.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: issues one butterfly
// read per cycle, drains the bfu pipeline between stages and replays addresses as writes.
module fft_agu #(
    parameter int N       = 16,
    parameter int BFU_LAT = 3,
    parameter int MEM_LAT = 1,
    localparam int LOG2N  = $clog2(N),
    localparam int SW     = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [SW-1:0]    stage
);

    localparam int KW  = LOG2N - 1;
    localparam int DLY = MEM_LAT + BFU_LAT;
    localparam int CW  = $clog2(DLY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                busy_q, done_q, rd_en_q;
    logic [LOG2N-1:0]    rda_q, rdb_q;
    logic [KW-1:0]       tw_q;
    logic [DLY-1:0]                 wen_q;
    logic [DLY-1:0][LOG2N-1:0]      wa_q, wb_q;

    logic [LOG2N-1:0]    kx, hbit, hmask, a_d, b_d;
    logic [KW-1:0]       tw_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                if (k_q == KW'(N / 2 - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DLY - 1)) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // a inserts a zero at bit s of k (the butterfly span); b sets that bit.
    always_comb begin
        kx    = {1'b0, k_d};
        hbit  = LOG2N'(1) << stage_d;
        hmask = hbit - LOG2N'(1);
        a_d   = ((kx & ~hmask) << 1) | (kx & hmask);
        b_d   = a_d | hbit;
        tw_d  = (k_d & hmask[KW-1:0]) << (KW - int'(stage_d));
        if (state_d != S_RUN) begin
            a_d  = '0;
            b_d  = '0;
            tw_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rda_q   <= '0;
            rdb_q   <= '0;
            tw_q    <= '0;
            wen_q   <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            rd_en_q <= (state_d == S_RUN);
            rda_q   <= a_d;
            rdb_q   <= b_d;
            tw_q    <= tw_d;
            wen_q[0] <= rd_en_q;
            wa_q[0]  <= rda_q;
            wb_q[0]  <= rdb_q;
            for (int unsigned i = 1; i < DLY; i++) begin
                wen_q[i] <= wen_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rda_q;
    assign rd_addr_b = rdb_q;
    assign tw_addr   = tw_q;
    assign wr_en     = wen_q[DLY-1];
    assign wr_addr_a = wa_q[DLY-1];
    assign wr_addr_b = wb_q[DLY-1];
    assign stage     = stage_q;

endmodule

// File: tb/tb_fft_agu.sv
// Scoreboard bench for fft_agu: expected butterfly order is built from nested
// group/offset loops; per-cycle control timing is derived from the stage length.
module tb_fft_agu;

    localparam int N       = 16;
    localparam int BFU_LAT = 3;
    localparam int MEM_LAT = 1;
    localparam int LOG2N   = $clog2(N);
    localparam int SW      = $clog2(LOG2N);
    localparam int LAT     = MEM_LAT + BFU_LAT;
    localparam int STG_LEN = N / 2 + LAT;
    localparam int TOTAL   = LOG2N * STG_LEN;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, rd_en, wr_en;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic [SW-1:0]    stage;

    fft_agu #(.N(N), .BFU_LAT(BFU_LAT), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b), .stage(stage)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int b; int tw;} rec_t;
    rec_t rdq[$];
    rec_t wrq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stage s pairs elements h=2^s apart inside blocks of 2h; twiddle step N/(2h).
    task automatic push_model();
        for (int s = 0; s < LOG2N; s++) begin
            int h;
            h = 1 << s;
            for (int base = 0; base < N; base += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    rec_t r;
                    r.a  = base + j;
                    r.b  = base + j + h;
                    r.tw = j * (N / (2 * h));
                    rdq.push_back(r);
                    wrq.push_back(r);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b,
                          tw_addr, wr_addr_a, wr_addr_b, stage}), 0);
    endtask

    // Monitor: per-cycle control timing plus scoreboard pops on rd_en / wr_en.
    always @(negedge clk) begin
        int n;
        int ph;
        int exp_ctrl;
        n = cyc - start_cyc + 1;
        if (active && n >= 1 && n <= TOTAL) begin
            ph = (n - 1) % STG_LEN;
            exp_ctrl = {1'b1, 1'b0, ph < N / 2, ph >= LAT};
            check("ctrl", int'({busy, done, rd_en, wr_en}), exp_ctrl);
            check("stage", int'(stage), (n - 1) / STG_LEN);
        end else if (active && n == TOTAL + 1) begin
            check("done_ctrl", int'({busy, done, rd_en, wr_en}), 4'b0100);
        end else begin
            check("idle_ctrl", int'({busy, done, rd_en, wr_en, stage}), 0);
        end
        if (rd_en) begin
            if (rdq.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                rec_t e;
                e = rdq.pop_front();
                check("rd_addr", int'({rd_addr_a, rd_addr_b, tw_addr}),
                      (e.a << (2 * LOG2N - 1)) | (e.b << (LOG2N - 1)) | e.tw);
            end
        end
        if (wr_en) begin
            if (wrq.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                rec_t e;
                e = wrq.pop_front();
                check("wr_addr", int'({wr_addr_a, wr_addr_b}), (e.a << LOG2N) | e.b);
            end
        end
    end

    task automatic run_transform(input int abort_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        active = 1'b1;
        push_model();
        for (int n = 1; n <= TOTAL; n++) begin
            if (n == abort_n) begin
                start = 1'b0;
                #3;
                rst = 1'b0;
                active = 1'b0;
                rdq.delete();
                wrq.delete();
                #1;
                check_all_zero("async_reset");
                tick();
                tick();
                rst = 1'b1;
                return;
            end
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = $urandom_range(0, 1) != 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check_all_zero("reset_state");
        rst = 1'b1;
        tick();
        tick();
        for (int t = 0; t < 6; t++) begin
            int gap;
            gap = (t == 1 || t == 4) ? 0 : $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) tick();
            if (t == 2) begin
                run_transform($urandom_range(2 * STG_LEN + 1, 3 * STG_LEN));
                for (int g = 0; g < 6; g++) tick();
            end else begin
                run_transform(0);
            end
        end
        for (int g = 0; g < 4; g++) tick();
        check("rdq_drained", rdq.size(), 0);
        check("wrq_drained", wrq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
